// File: rtl/uart_rx_cmd_pkg.sv
// uart_rx_cmd_pkg: shared command codes, header default and FSM state encodings
package uart_rx_cmd_pkg;
  localparam logic [7:0] CMD_FAN = 8'h01;
  localparam logic [7:0] CMD_BUZ = 8'h02;
  localparam logic [7:0] CMD_ALL_OFF = 8'h03;
  localparam logic [7:0] HEADER_DEF = 8'hAA;
  typedef enum logic [2:0] {B_IDLE, B_START, B_DATA, B_STOP, B_BREAK} byte_st_e;
  typedef enum logic [1:0] {P_HDR, P_CMD, P_ARG, P_SUM} pkt_st_e;
endpackage

// File: rtl/uart_rx_cmd_if.sv
// uart_rx_cmd_if: serial input plus received-byte, command and actuator outputs
interface uart_rx_cmd_if;
  logic rxd;
  logic [7:0] rx_data, cmd_code, cmd_arg;
  logic rx_done, frame_err, cmd_valid, cmd_err, fan_on, buzzer_on;
  modport master (output rxd, input rx_data, rx_done, frame_err, cmd_valid, cmd_code, cmd_arg, cmd_err, fan_on, buzzer_on);
  modport slave (input rxd, output rx_data, rx_done, frame_err, cmd_valid, cmd_code, cmd_arg, cmd_err, fan_on, buzzer_on);
endinterface

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 byte receiver (in: clk, rst, rxd; out: rx_data, rx_done, frame_err)
module uart_rx_byte import uart_rx_cmd_pkg::*; #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err
);
  localparam int BIT_CNT = CLK_FREQ / BAUD;
  localparam int CW = $clog2(BIT_CNT + 1);
  localparam logic [CW-1:0] FULL = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] HALF = CW'(BIT_CNT / 2 - 1);
  logic s1_q, s2_q, s3_q;
  byte_st_e st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d, data_q, data_d;
  logic done_q, done_d, ferr_q, ferr_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
      st_q <= B_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      data_q <= '0;
      done_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      s1_q <= rxd;
      s2_q <= s1_q;
      s3_q <= s2_q;
      st_q <= st_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      data_q <= data_d;
      done_q <= done_d;
      ferr_q <= ferr_d;
    end
  end
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q + 1'b1;
    bit_d = bit_q;
    sh_d = sh_q;
    data_d = data_q;
    done_d = 1'b0;
    ferr_d = 1'b0;
    case (st_q)
      B_IDLE: begin
        cnt_d = '0;
        st_d = (s3_q & ~s2_q) ? B_START : B_IDLE;
      end
      B_START: if (cnt_q == HALF) begin
        cnt_d = '0;
        bit_d = '0;
        st_d = s2_q ? B_IDLE : B_DATA;
      end
      B_DATA: if (cnt_q == FULL) begin
        cnt_d = '0;
        sh_d = {s2_q, sh_q[7:1]};
        bit_d = bit_q + 1'b1;
        st_d = (bit_q == 3'd7) ? B_STOP : B_DATA;
      end
      B_STOP: if (cnt_q == FULL) begin
        cnt_d = '0;
        st_d = s2_q ? B_IDLE : B_BREAK;
        done_d = s2_q;
        ferr_d = ~s2_q;
        data_d = s2_q ? sh_q : data_q;
      end
      B_BREAK: begin
        cnt_d = '0;
        st_d = s2_q ? B_IDLE : B_BREAK;
      end
      default: st_d = B_IDLE;
    endcase
  end
  assign rx_data = data_q;
  assign rx_done = done_q;
  assign frame_err = ferr_q;
endmodule

// File: rtl/uart_rx_cmd.sv
// uart_rx_cmd: UART command-packet receiver (in: clk, rst, bus.rxd; out: bus bytes, command pulses, fan/buzzer levels)
module uart_rx_cmd import uart_rx_cmd_pkg::*; #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD = 9600,
  parameter logic [7:0] HEADER = HEADER_DEF,
  parameter int TIMEOUT_BITS = 20
) (
  input logic clk,
  input logic rst,
  uart_rx_cmd_if.slave bus
);
  localparam int LIMIT = TIMEOUT_BITS * (CLK_FREQ / BAUD);
  localparam int TW = $clog2(LIMIT + 1);
  logic [7:0] byte_w;
  logic done_w, ferr_w;
  pkt_st_e pst_q, pst_d;
  logic [7:0] cmd_q, cmd_d, arg_q, arg_d, code_q, code_d, carg_q, carg_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic vld_q, vld_d, err_q, err_d, fan_q, fan_d, buz_q, buz_d;
  uart_rx_byte #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_byte (
    .clk(clk), .rst(rst), .rxd(bus.rxd), .rx_data(byte_w), .rx_done(done_w), .frame_err(ferr_w)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      pst_q <= P_HDR;
      cmd_q <= '0;
      arg_q <= '0;
      code_q <= '0;
      carg_q <= '0;
      tmo_q <= '0;
      vld_q <= 1'b0;
      err_q <= 1'b0;
      fan_q <= 1'b0;
      buz_q <= 1'b0;
    end else begin
      pst_q <= pst_d;
      cmd_q <= cmd_d;
      arg_q <= arg_d;
      code_q <= code_d;
      carg_q <= carg_d;
      tmo_q <= tmo_d;
      vld_q <= vld_d;
      err_q <= err_d;
      fan_q <= fan_d;
      buz_q <= buz_d;
    end
  end
  always_comb begin
    pst_d = pst_q;
    cmd_d = cmd_q;
    arg_d = arg_q;
    code_d = code_q;
    carg_d = carg_q;
    vld_d = 1'b0;
    err_d = 1'b0;
    fan_d = fan_q;
    buz_d = buz_q;
    tmo_d = (pst_q == P_HDR || done_w) ? '0 : tmo_q + 1'b1;
    if (done_w) begin
      case (pst_q)
        P_HDR: pst_d = (byte_w == HEADER) ? P_CMD : P_HDR;
        P_CMD: begin
          cmd_d = byte_w;
          pst_d = P_ARG;
        end
        P_ARG: begin
          arg_d = byte_w;
          pst_d = P_SUM;
        end
        P_SUM: begin
          pst_d = P_HDR;
          vld_d = byte_w == 8'(cmd_q + arg_q);
          err_d = ~vld_d;
          code_d = vld_d ? cmd_q : code_q;
          carg_d = vld_d ? arg_q : carg_q;
          fan_d = !vld_d ? fan_q : cmd_q == CMD_FAN ? |arg_q : cmd_q == CMD_ALL_OFF ? 1'b0 : fan_q;
          buz_d = !vld_d ? buz_q : cmd_q == CMD_BUZ ? |arg_q : cmd_q == CMD_ALL_OFF ? 1'b0 : buz_q;
        end
        default: pst_d = P_HDR;
      endcase
    end else if (pst_q != P_HDR && (ferr_w || tmo_d == TW'(LIMIT))) begin
      pst_d = P_HDR;
      tmo_d = '0;
    end
  end
  assign bus.rx_data = byte_w;
  assign bus.rx_done = done_w;
  assign bus.frame_err = ferr_w;
  assign bus.cmd_valid = vld_q;
  assign bus.cmd_err = err_q;
  assign bus.cmd_code = code_q;
  assign bus.cmd_arg = carg_q;
  assign bus.fan_on = fan_q;
  assign bus.buzzer_on = buz_q;
endmodule

// File: doc/uart_rx_cmd.md
Name: uart_rx_cmd

Overview:
UART 8N1 receiver with a command-packet parser, the receive-side counterpart of the board's sensor-report transmitter. It recovers bytes from the serial line driven by the host or phone module. It then assembles fixed 4-byte command packets, checks them, and drives the fan and buzzer control levels. Its outputs feed the actuator logic next to the transmitter path in the board top level.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD, 9600, line rate; BIT_CNT = CLK_FREQ/BAUD clocks per bit (integer division)
HEADER, 8'hAA, packet start byte
TIMEOUT_BITS, 20, idle bit-times allowed between bytes of one packet before the packet is abandoned

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
rxd  in  1  asynchronous serial input, idle high
rx_data  out  8  last correctly framed byte
rx_done  out  1  1-cycle pulse: rx_data updated
frame_err  out  1  1-cycle pulse: stop bit sampled low
cmd_valid  out  1  1-cycle pulse: packet accepted
cmd_code  out  8  command byte of the last accepted packet
cmd_arg  out  8  argument byte of the last accepted packet
cmd_err  out  1  1-cycle pulse: checksum mismatch
fan_on  out  1  fan control level
buzzer_on  out  1  buzzer control level

Behaviour:
- Single clock domain. Reset is synchronous and active-high on clk; there is no other clock.
- Reset values:
  - rx_data, cmd_code and cmd_arg are 0.
  - All pulse outputs are 0.
  - fan_on and buzzer_on are 0.
  - The synchronizer flops are 1.
  - Both FSMs are idle and all counters are 0.
- Reset mid-byte or mid-packet discards all partial state. No pulse is issued.
- Input sync: rxd passes through a 2-FF synchronizer. A falling edge is detected on the synchronized value, giving 2-3 cycles of input latency.
- Byte FSM:
  - IDLE: on a falling edge go to START with the bit counter cleared.
  - START: wait BIT_CNT/2 clocks, then resample. If low, go to DATA. If high, treat it as a glitch and return to IDLE.
  - DATA: sample every BIT_CNT clocks. 8 bits, LSB first, into a shift register.
  - STOP: sample after BIT_CNT clocks.
    - High: load rx_data and pulse rx_done on the next cycle, then go to IDLE.
    - Low: pulse frame_err, leave rx_data unchanged, go to BREAK.
  - BREAK: wait until the synchronized line is high, then go to IDLE. This means a held-low break produces exactly one frame_err.
- Parser FSM (advances only on rx_done):
  - P_HDR: a byte equal to HEADER goes to P_CMD; any other byte is ignored.
  - P_CMD: latch the command byte, go to P_ARG.
  - P_ARG: latch the argument byte, go to P_SUM.
  - P_SUM: compare the byte with (cmd + arg) mod 256, using 8-bit wraparound.
    - Match: update cmd_code and cmd_arg, pulse cmd_valid, apply the command.
    - Mismatch: pulse cmd_err; outputs unchanged.
    - Either way, return to P_HDR.
- The cmd_valid and cmd_err pulses fire 1 cycle after the rx_done of the checksum byte.
- A HEADER value seen inside a packet is treated as ordinary data. There is no mid-packet resync.
- A frame_err while the parser is outside P_HDR abandons the packet (return to P_HDR, no pulse).
- Timeout: a counter runs while the parser is outside P_HDR and clears on each rx_done. When it reaches TIMEOUT_BITS*BIT_CNT, the parser returns to P_HDR with no pulse.
- Command effects, registered in the same cycle cmd_valid is asserted:
  - 0x01: fan_on = (arg != 0).
  - 0x02: buzzer_on = (arg != 0).
  - 0x03: fan_on = 0 and buzzer_on = 0.
  - Any other code: cmd_valid still pulses; the levels are unchanged.
- Simultaneous events: a timeout and an rx_done in the same cycle resolve in favour of rx_done, because the counter clears.

Decomposition:
- Shared package holds:
  - The command codes CMD_FAN = 8'h01, CMD_BUZ = 8'h02 and CMD_ALL_OFF = 8'h03.
  - The HEADER default.
  - The byte-FSM and parser-FSM state encodings.
- The byte receiver is split out as sub-module uart_rx_byte. Its ports are clk, rst, rxd, rx_data, rx_done and frame_err, with CLK_FREQ and BAUD as parameters.
- uart_rx_cmd instantiates uart_rx_byte and contains the parser, the timeout counter and the control registers.

Test Plan:
- Simulation uses CLK_FREQ=1_000_000 and BAUD=100_000, so BIT_CNT=10.
- Send byte 0x5A -> exactly one rx_done; rx_data=0x5A; no frame_err.
- Send packet AA 01 01 02 -> cmd_valid one cycle after the 4th rx_done; cmd_code=0x01, cmd_arg=0x01; fan_on=1.
- Send AA 02 FF 01 (0x02+0xFF wraps to 0x01) -> cmd_valid; buzzer_on=1. Then send AA 02 FF 00 -> cmd_err pulse; buzzer_on stays 1.
- Send a 0x33 byte with its stop bit forced low -> one frame_err; rx_data unchanged. Then hold the line low for 50 bit-times -> no further frame_err. Release the line and send 0x11 -> rx_done with 0x11.
- Send AA 01, stay idle 25 bit-times, then send 01 02 -> no cmd_valid; fan_on unchanged. A following complete AA 03 00 03 -> cmd_valid; fan_on=0 and buzzer_on=0.
- Drive a 3-clock low glitch on rxd -> no rx_done and no frame_err. Assert rst in the middle of the DATA state of a byte -> all outputs 0 and no pulse; the next full packet is accepted normally.
